// File: rtl/router_fifo_pkg.sv
// Shared constants and the tagged storage word for the router output buffer.
// Header byte layout: destination in [1:0], payload length in [7:2].
package router_fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int CNT_WIDTH  = 6;

  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  typedef struct packed {
    logic                  hdr;
    logic [DATA_WIDTH-1:0] data;
  } tagged_word_t;

  // Bytes left in a packet once its header has been read: payload plus parity.
  function automatic logic [CNT_WIDTH-1:0] pkt_len(input logic [DATA_WIDTH-1:0] hdr_byte);
    return hdr_byte[HDR_LEN_MSB:HDR_LEN_LSB] + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake bundle between the router core and one output buffer.
interface router_fifo_if;
  import router_fifo_pkg::*;

  logic                  write_enb;
  logic                  read_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  empty, full, data_out
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output empty, full, data_out
  );

endinterface

// File: rtl/router_fifo.sv
// Per-destination output buffer: tags header bytes on write and tracks the
// remaining bytes of the packet being read so the read bus idles at zero.
module router_fifo
  import router_fifo_pkg::*;
(
  input logic          clock,
  input logic          reset,
  input logic          soft_reset,
  router_fifo_if.slave bus
);

  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]      hdr_tag;
  logic [CNT_WIDTH-1:0]  pkt_count;
  logic                  lfd_d;
  logic                  clear;
  logic                  do_write;
  logic                  do_read;
  tagged_word_t          rd_word;

  assign clear    = reset | soft_reset;
  assign bus.empty = (wr_ptr == rd_ptr);
  assign bus.full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign do_write = bus.write_enb && !bus.full;
  assign do_read  = bus.read_enb && !bus.empty;

  assign rd_word.hdr  = hdr_tag[rd_ptr[ADDR_WIDTH-1:0]];
  assign rd_word.data = mem_data[rd_ptr[ADDR_WIDTH-1:0]];

  // Data storage needs no reset; a write coinciding with a reset is discarded.
  always_ff @(posedge clock) begin
    if (!clear && do_write) begin
      mem_data[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_count    <= '0;
      lfd_d        <= 1'b0;
      hdr_tag      <= '0;
      bus.data_out <= '0;
    end else begin
      // lfd_state leads the header byte by one clock; delay it to tag that byte.
      lfd_d <= bus.lfd_state;

      if (do_write) begin
        hdr_tag[wr_ptr[ADDR_WIDTH-1:0]] <= lfd_d;
        wr_ptr                          <= wr_ptr + ptr_t'(1);
      end

      if (do_read) begin
        rd_ptr       <= rd_ptr + ptr_t'(1);
        bus.data_out <= rd_word.data;
        if (rd_word.hdr) begin
          pkt_count <= pkt_len(rd_word.data);
        end else if (pkt_count != '0) begin
          pkt_count <= pkt_count - CNT_WIDTH'(1);
        end
      end else if (pkt_count == '0) begin
        bus.data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_router_fifo;

  logic clock;
  logic reset;
  logic soft_reset;

  router_fifo_if bus();

  router_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int failures;

  // Reference model state: stored words as {hdr_flag, byte}.
  logic [8:0] model_q[$];
  int         model_pkt;
  logic [7:0] model_dout;
  logic       model_lfd_d;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model advances alongside and all outputs are checked.
  task automatic applyStimulus(input logic rst, input logic srst, input logic we,
                               input logic re, input logic lfd, input logic [7:0] din);
    bit         wr_ok;
    bit         rd_ok;
    logic [8:0] w;
    reset          = rst;
    soft_reset     = srst;
    bus.write_enb  = we;
    bus.read_enb   = re;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    @(posedge clock);
    #1;
    if (rst || srst) begin
      model_q.delete();
      model_pkt   = 0;
      model_dout  = 8'h00;
      model_lfd_d = 1'b0;
    end else begin
      wr_ok = we && (model_q.size() < 16);
      rd_ok = re && (model_q.size() > 0);
      if (rd_ok) begin
        w          = model_q.pop_front();
        model_dout = w[7:0];
        if (w[8]) model_pkt = ((w[7:0] >> 2) + 1) % 64;
        else if (model_pkt > 0) model_pkt = model_pkt - 1;
      end else if (model_pkt == 0) begin
        model_dout = 8'h00;
      end
      if (wr_ok) model_q.push_back({model_lfd_d, din});
      model_lfd_d = lfd;
    end
    checkOutput("empty", 32'(bus.empty), 32'(model_q.size() == 0));
    checkOutput("full", 32'(bus.full), 32'(model_q.size() == 16));
    checkOutput("data_out", 32'(bus.data_out), 32'(model_dout));
    checkOutput("pkt_count", 32'(dut.pkt_count), 32'(model_pkt));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic lfd);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, lfd, d);
  endtask

  task automatic read_byte();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] pkt_a[5];
    logic [5:0] cnt_a[5];
    logic [7:0] pkt_b[4];
    logic [7:0] rnd;
    checks      = 0;
    failures    = 0;
    model_pkt   = 0;
    model_dout  = 8'h00;
    model_lfd_d = 1'b0;
    reset       = 1'b1;
    soft_reset  = 1'b0;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = 8'h00;

    // Reset for two clocks
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_dout", 32'(bus.data_out), 32'h00);

    // Single packet: header 0D (length 3), three payload bytes, parity
    pkt_a = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h3F};
    cnt_a = '{6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) write_byte(pkt_a[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      read_byte();
      checkOutput("pkt_dout", 32'(bus.data_out), 32'(pkt_a[i]));
      checkOutput("pkt_cnt", 32'(dut.pkt_count), 32'(cnt_a[i]));
    end
    idle();
    checkOutput("pkt_idle", 32'(bus.data_out), 32'h00);

    // Fill to full, overflow write dropped, drain in order
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0);
    checkOutput("fill_full", 32'(bus.full), 32'd1);
    write_byte(8'hFF, 1'b0);
    checkOutput("ovf_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      read_byte();
      checkOutput("drain_dout", 32'(bus.data_out), 32'(i));
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    // Full with simultaneous read and write: read wins, write dropped
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    checkOutput("rw_full_dout", 32'(bus.data_out), 32'h00);
    checkOutput("rw_full_flag", 32'(bus.full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      read_byte();
      checkOutput("rw_rest", 32'(bus.data_out), 32'(i));
    end
    checkOutput("rw_empty", 32'(bus.empty), 32'd1);

    // Soft reset mid-packet, then a fresh packet
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) write_byte(pkt_a[i], 1'b0);
    for (int i = 0; i < 3; i++) read_byte();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("srst_empty", 32'(bus.empty), 32'd1);
    checkOutput("srst_dout", 32'(bus.data_out), 32'h00);
    checkOutput("srst_cnt", 32'(dut.pkt_count), 32'd0);
    pkt_b = '{8'h09, 8'hA1, 8'hA2, 8'h5B};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) write_byte(pkt_b[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      read_byte();
      checkOutput("post_srst", 32'(bus.data_out), 32'(pkt_b[i]));
    end
    checkOutput("post_srst_cnt", 32'(dut.pkt_count), 32'd0);

    // Pointer wrap over three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        rnd = 8'($urandom);
        write_byte(rnd, 1'b0);
      end
      for (int i = 0; i < 10; i++) read_byte();
      checkOutput("wrap_empty", 32'(bus.empty), 32'd1);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
